// File: rtl/vm_coin_front.sv
// Coin sensor front end: two-flop sync, debounce and rise detect per channel,
// then serialise accepted coins into one-cycle D_in codes and a saturating credit total.
module vm_coin_front #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       coin_half_raw,
    input  logic       coin_one_raw,
    output logic [1:0] D_in,
    output logic [7:0] credit_total
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CODE_IDLE = 2'b00;
    localparam logic [1:0] CODE_HALF = 2'b01;
    localparam logic [1:0] CODE_ONE  = 2'b10;

    // Bit 0 is the 0.5-yuan channel, bit 1 the 1-yuan channel.
    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       deb_dly_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       rise;

    logic             pend_one_q, pend_one_d;
    logic [1:0]       d_in_q, d_in_d;
    logic [7:0]       credit_q, credit_d;
    logic [8:0]       credit_sum;

    assign raw  = {coin_one_raw, coin_half_raw};
    assign rise = deb_q & ~deb_dly_q;

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            deb_d[ch] = deb_q[ch];
            cnt_d[ch] = '0;
            if (sync2_q[ch] != deb_q[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    deb_d[ch] = sync2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end
    end

    // A simultaneous pair goes out half first; the 1-yuan code is held one cycle.
    always_comb begin
        d_in_d     = CODE_IDLE;
        pend_one_d = 1'b0;
        if (pend_one_q) begin
            d_in_d = CODE_ONE;
        end else begin
            case (rise)
                2'b01:   d_in_d = CODE_HALF;
                2'b10:   d_in_d = CODE_ONE;
                2'b11: begin
                    d_in_d     = CODE_HALF;
                    pend_one_d = 1'b1;
                end
                default: d_in_d = CODE_IDLE;
            endcase
        end
    end

    always_comb begin
        credit_sum = {1'b0, credit_q};
        if (d_in_d == CODE_HALF) begin
            credit_sum = {1'b0, credit_q} + 9'd1;
        end else if (d_in_d == CODE_ONE) begin
            credit_sum = {1'b0, credit_q} + 9'd2;
        end
        credit_d = credit_sum[8] ? 8'hFF : credit_sum[7:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_dly_q  <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            pend_one_q <= 1'b0;
            d_in_q     <= CODE_IDLE;
            credit_q   <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_dly_q  <= deb_q;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            pend_one_q <= pend_one_d;
            d_in_q     <= d_in_d;
            credit_q   <= credit_d;
        end
    end

    assign D_in         = d_in_q;
    assign credit_total = credit_q;

endmodule
